// File: rtl/burst_mem_pkg.sv
// Shared types and default parameters for the burst memory model.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DEF_NUM_PORTS   = 2;
  localparam int unsigned DEF_BEAT_W      = 64;
  localparam int unsigned DEF_BURST_LEN   = 4;
  localparam int unsigned DEF_DEPTH_LINES = 256;
  localparam int unsigned DEF_MISS_CYCLES = 10;
  localparam int unsigned DEF_HIT_CYCLES  = 5;
  localparam int unsigned DEF_PAGE_BITS   = 8;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from a rotating pointer.
module rr_arbiter
  import burst_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int unsigned PORT_W = clog2_min1(NUM_PORTS);

  logic [PORT_W-1:0] ptr_q;
  logic [PORT_W-1:0] ptr_d;
  logic [PORT_W-1:0] idx;
  logic              found;

  // Search requesters from the pointer; the port after the winner becomes the next pointer.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PORT_W'((32'(ptr_q) + 32'(i)) % NUM_PORTS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PORT_W'((32'(idx) + 32'd1) % NUM_PORTS);
      end
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/burst_mem_model.sv
// Multi-port burst memory model with open-page hit/miss latency.
module burst_mem_model
  import burst_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
  parameter int unsigned BEAT_W      = DEF_BEAT_W,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned DEPTH_LINES = DEF_DEPTH_LINES,
  parameter int unsigned MISS_CYCLES = DEF_MISS_CYCLES,
  parameter int unsigned HIT_CYCLES  = DEF_HIT_CYCLES,
  parameter int unsigned PAGE_BITS   = DEF_PAGE_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        read,
  input  logic [NUM_PORTS-1:0]        write,
  input  logic [NUM_PORTS*ADDR_W-1:0] address,
  input  logic [NUM_PORTS*BEAT_W-1:0] wdata,
  output logic [NUM_PORTS*BEAT_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]        resp,
  output logic                        err,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int unsigned PORT_W  = clog2_min1(NUM_PORTS);
  localparam int unsigned BEAT_IW = clog2_min1(BURST_LEN);
  localparam int unsigned LINE_W  = clog2_min1(DEPTH_LINES);
  localparam int unsigned OFS_W   = $clog2(BURST_LEN * BEAT_W / 8);
  localparam int unsigned PAGE_W  = ADDR_W - PAGE_BITS;
  localparam int unsigned CNT_W   = clog2_min1(MISS_CYCLES);
  localparam logic [BEAT_IW-1:0] LAST_BEAT = BEAT_IW'(BURST_LEN - 1);

  // Backing store starts zeroed and is deliberately untouched by reset.
  logic [BEAT_W-1:0] mem [DEPTH_LINES][BURST_LEN] = '{default: '0};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_IW-1:0]  beat_q, beat_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                wr_q, wr_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic                page_vld_q, page_vld_d;
  logic [31:0]         hit_d, miss_d;
  logic                err_d;
  logic [NUM_PORTS-1:0]        resp_d;
  logic [NUM_PORTS*BEAT_W-1:0] rdata_d;
  logic                mem_we;
  logic [BEAT_W-1:0]   wbeat;

  logic [NUM_PORTS-1:0] eligible, conflict, arb_req, grant;
  logic                 arb_advance;
  logic [PORT_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]    gnt_addr;
  logic                 gnt_wr;
  logic [PAGE_W-1:0]    gnt_page;
  logic                 unused_addr_bits;

  assign eligible    = read ^ write;
  assign conflict    = read & write;
  assign arb_req     = (state_q == IDLE) ? eligible : '0;
  assign arb_advance = (state_q == IDLE);
  assign gnt_page    = gnt_addr[ADDR_W-1:PAGE_BITS];
  assign unused_addr_bits = ^gnt_addr[OFS_W-1:0];

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (grant)
  );

  // Pick out the granted port's request fields and the serviced port's write beat.
  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_wr   = 1'b0;
    wbeat    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        gnt_idx  = PORT_W'(p);
        gnt_addr = address[p*ADDR_W +: ADDR_W];
        gnt_wr   = write[p];
      end
      if (port_q == PORT_W'(p)) begin
        wbeat = wdata[p*BEAT_W +: BEAT_W];
      end
    end
  end

  // Next-state, page tracking and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    port_d     = port_q;
    line_d     = line_q;
    wr_d       = wr_q;
    page_d     = page_q;
    page_vld_d = page_vld_q;
    hit_d      = hit_count;
    miss_d     = miss_count;
    err_d      = err;
    resp_d     = '0;
    rdata_d    = '0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|conflict) err_d = 1'b1;
        if (|grant) begin
          port_d     = gnt_idx;
          line_d     = gnt_addr[OFS_W +: LINE_W];
          wr_d       = gnt_wr;
          page_d     = gnt_page;
          page_vld_d = 1'b1;
          state_d    = WAIT;
          if (page_vld_q && (gnt_page == page_q)) begin
            cnt_d = CNT_W'(HIT_CYCLES - 1);
            if (hit_count != 32'hFFFF_FFFF) hit_d = hit_count + 32'd1;
          end else begin
            cnt_d = CNT_W'(MISS_CYCLES - 1);
            if (miss_count != 32'hFFFF_FFFF) miss_d = miss_count + 32'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BURST: begin
        mem_we = wr_q;
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + BEAT_IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == BURST) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_d == PORT_W'(p)) begin
          resp_d[p] = 1'b1;
          if (!wr_d) rdata_d[p*BEAT_W +: BEAT_W] = mem[line_d][beat_d];
        end
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      port_q     <= '0;
      line_q     <= '0;
      wr_q       <= 1'b0;
      page_q     <= '0;
      page_vld_q <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      err        <= 1'b0;
      resp       <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      port_q     <= port_d;
      line_q     <= line_d;
      wr_q       <= wr_d;
      page_q     <= page_d;
      page_vld_q <= page_vld_d;
      hit_count  <= hit_d;
      miss_count <= miss_d;
      err        <= err_d;
      resp       <= resp_d;
      rdata      <= rdata_d;
    end
  end

  // Write beats land at the end of each resp cycle.
  always_ff @(posedge clk) begin
    if (mem_we) mem[line_q][beat_q] <= wbeat;
  end

endmodule

// File: tb/tb_burst_mem_model.sv
// Directed self-checking bench for burst_mem_model with default parameters.
module tb_burst_mem_model;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   read, write;
  logic [63:0]  address;
  logic [127:0] wdata, rdata;
  logic [1:0]   resp;
  logic         err;
  logic [31:0]  hit_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  burst_mem_model dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .resp       (resp),
    .err        (err),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One transaction from an idle DUT; latency counted in edges after the grant edge.
  task automatic run_txn(input int p, input bit wr, input logic [31:0] a,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3,
                         input int exp_lat, input string tag);
    logic [63:0] beats [4];
    int n, got, lat;
    beats[0] = d0; beats[1] = d1; beats[2] = d2; beats[3] = d3;
    address[p*32 +: 32] = a;
    wdata[p*64 +: 64]   = d0;
    read[p]  = ~wr;
    write[p] = wr;
    n = 0; got = 0; lat = -1;
    while (got < 4 && n < 60) begin
      tick();
      n++;
      if (wr) wdata[p*64 +: 64] = beats[got];
      if (resp != 2'b00) begin
        check({tag, " onehot"}, 64'(resp), 64'(2'b01 << p));
        if (got == 0) begin
          lat = n - 1;
          check({tag, " latency"}, 64'(lat), 64'(exp_lat));
          if (!wr) check({tag, " other_rdata"}, rdata[(1-p)*64 +: 64], 64'd0);
        end
        if (!wr) check({tag, " beat"}, rdata[p*64 +: 64], beats[got]);
        got++;
      end
    end
    if (got < 4) check({tag, " timeout"}, 64'(got), 64'd4);
    tick();
    read[p]  = 1'b0;
    write[p] = 1'b0;
    tick();
  endtask

  initial begin
    int n, got, nb;
    int starts [4];
    int ports [4];
    bit prev;
    for (int k = 0; k < 4; k++) begin
      starts[k] = 0;
      ports[k]  = -1;
    end

    rst = 1'b0; read = '0; write = '0; address = '0; wdata = '0;
    tick();
    tick();
    check("reset resp", 64'(resp), 64'd0);
    check("reset rdata", rdata[63:0] | rdata[127:64], 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset hit", 64'(hit_count), 64'd0);
    check("reset miss", 64'(miss_count), 64'd0);
    rst = 1'b1;

    // Write then read back the same page: miss then hit.
    run_txn(0, 1'b1, 32'h100, 64'h11, 64'h22, 64'h33, 64'h44, 10, "wr_miss");
    run_txn(0, 1'b0, 32'h100, 64'h11, 64'h22, 64'h33, 64'h44, 5, "rd_hit");
    check("hit after rd", 64'(hit_count), 64'd1);
    check("miss after wr", 64'(miss_count), 64'd1);

    // Reset invalidates the open page but keeps storage; two different pages both miss.
    do_reset();
    run_txn(0, 1'b0, 32'h100, 64'h11, 64'h22, 64'h33, 64'h44, 10, "rd_post_rst");
    run_txn(0, 1'b0, 32'h220, 64'h0, 64'h0, 64'h0, 64'h0, 10, "rd_page2");
    check("two miss count", 64'(miss_count), 64'd2);
    check("two miss hit", 64'(hit_count), 64'd0);

    // Port1 with read and write both high is flagged and never served.
    address[63:32] = 32'h300;
    read[1] = 1'b1;
    write[1] = 1'b1;
    run_txn(0, 1'b0, 32'h100, 64'h11, 64'h22, 64'h33, 64'h44, 10, "rd_with_conflict");
    check("err sticky", 64'(err), 64'd1);
    read[1] = 1'b0;
    write[1] = 1'b0;

    // Reset after the second beat of a read aborts it at once.
    address[31:0] = 32'h100;
    read[0] = 1'b1;
    n = 0; got = 0;
    while (got < 2 && n < 40) begin
      tick();
      n++;
      if (resp[0]) got++;
    end
    check("abort beats seen", 64'(got), 64'd2);
    rst = 1'b0;
    #1;
    check("abort resp", 64'(resp), 64'd0);
    check("abort rdata", rdata[63:0] | rdata[127:64], 64'd0);
    check("abort err", 64'(err), 64'd0);
    check("abort hit", 64'(hit_count), 64'd0);
    check("abort miss", 64'(miss_count), 64'd0);
    read[0] = 1'b0;
    tick();
    rst = 1'b1;
    run_txn(0, 1'b0, 32'h100, 64'h11, 64'h22, 64'h33, 64'h44, 10, "rd_after_abort");
    check("abort recount miss", 64'(miss_count), 64'd1);
    check("abort recount hit", 64'(hit_count), 64'd0);

    // Addresses past the last line wrap back to line 0.
    run_txn(1, 1'b1, 32'h0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 10, "wr_line0");
    run_txn(0, 1'b0, 32'h2000, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 10, "rd_wrap");
    check("wrap miss count", 64'(miss_count), 64'd3);

    // Both ports requesting continuously alternate with a fixed inter-burst spacing.
    do_reset();
    address[31:0]  = 32'h100;
    address[63:32] = 32'h2000;
    read = 2'b11;
    nb = 0; n = 0; prev = 1'b0;
    while (nb < 4 && n < 200) begin
      tick();
      n++;
      if ((|resp) && !prev) begin
        starts[nb] = n;
        ports[nb]  = resp[1] ? 1 : 0;
        nb++;
      end
      prev = |resp;
    end
    check("alt bursts", 64'(nb), 64'd4);
    repeat (3) tick();
    read = 2'b00;
    tick();
    tick();
    check("alt first start", 64'(starts[0]), 64'd11);
    for (int k = 0; k < 4; k++) begin
      check("alt port", 64'(ports[k]), 64'(k % 2));
    end
    for (int k = 1; k < 4; k++) begin
      check("alt spacing", 64'(starts[k] - starts[k-1]), 64'd16);
    end
    check("alt miss", 64'(miss_count), 64'd4);
    check("alt hit", 64'(hit_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_mem_model.md
BURST_MEM_MODEL -- requirements
Module: burst_mem_model

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of independent requester ports.
REQ-002 SHALL have parameter BEAT_W, default 64: data bits per beat.
REQ-003 SHALL have parameter BURST_LEN, default 4: beats per transaction (power of 2, >=1).
REQ-004 SHALL have parameter DEPTH_LINES, default 256: stored bursts (power of 2).
REQ-005 SHALL have parameters MISS_CYCLES (default 10) and HIT_CYCLES (default 5), with MISS_CYCLES>=HIT_CYCLES>=1.
REQ-006 SHALL have parameter PAGE_BITS, default 8: address bits below page number.
REQ-007 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have ports read and write, input, NUM_PORTS each: per-port request.
REQ-010 SHALL have port address, input, NUM_PORTS*32: per-port byte address.
REQ-011 SHALL have ports wdata (input) and rdata (output), NUM_PORTS*BEAT_W: per-port beat data.
REQ-012 SHALL have port resp, output, NUM_PORTS: per-port beat-valid strobe.
REQ-013 SHALL have port err, output, 1: sticky protocol-error flag.
REQ-014 SHALL have ports hit_count and miss_count, output, 32 each: saturating page-hit/miss counters.

Function
REQ-015 SHALL hold states IDLE, WAIT, BURST, DONE.
REQ-016 IDLE: port p eligible if exactly one of read[p]/write[p] is high; round-robin grant from pointer; pointer := (p+1) mod NUM_PORTS on grant; go WAIT.
REQ-017 Grant SHALL latch port, address, direction; requester SHALL hold them stable until its last resp.
REQ-018 Page = address[31:PAGE_BITS]; if page equals open page, latency HIT_CYCLES and hit_count++; else MISS_CYCLES and miss_count++; open page := page.
REQ-019 First resp SHALL assert exactly latency cycles after the grant edge.
REQ-020 BURST: resp[granted] high for BURST_LEN consecutive cycles, one beat each, beat index 0..BURST_LEN-1.
REQ-021 Read: rdata slice = stored beat for current index during resp; all non-resp rdata slices SHALL be zero.
REQ-022 Write: storage captures wdata slice at each resp edge; requester advances to next beat after each resp.
REQ-023 Line index = (address / (BURST_LEN*BEAT_W/8)) mod DEPTH_LINES; low offset bits ignored; out-of-range addresses wrap.
REQ-024 After last beat SHALL enter DONE for one cycle (granted port ineligible), then IDLE.
REQ-025 read and write both high on a port in IDLE: err := 1, port not granted that cycle; other ports arbitrate normally.
REQ-026 Counters SHALL saturate at 0xFFFF_FFFF.
REQ-027 Only one transaction in service at a time; resp at most one-hot.

Reset
REQ-028 rst low SHALL immediately force state IDLE, resp=0, rdata=0, err=0, counters=0, pointer=0, open page invalid (next access is a miss).
REQ-029 Reset mid-burst SHALL abort the transaction; beats already written remain stored.
REQ-030 Storage SHALL be zero at time 0 and SHALL NOT be cleared by reset.

Structure
REQ-031 Package burst_mem_pkg SHALL hold the state enum and default parameter constants.
REQ-032 Round-robin grant SHALL be one sub-module rr_arbiter (NUM_PORTS, req, advance, grant one-hot).

Verification
REQ-033 Port0 write 0x100, beats 0x11..0x44, then read 0x100 -> write resp at cycle 10 (miss), read data 0x11,0x22,0x33,0x44 after 5 cycles (hit).
REQ-034 Read 0x100 then 0x220 -> latencies 10 then 10; miss_count=2, hit_count=0.
REQ-035 Both ports request continuously -> grants alternate 0,1,0,1; DONE gap of one cycle between bursts.
REQ-036 Port1 read=write=1 while port0 reads -> err=1, port0 served, port1 never resp.
REQ-037 rst low after beat 2 of a read -> resp=0 same cycle; next read of same page shows latency 10, counters restart from 0.
REQ-038 Write line 0, read address DEPTH_LINES*32 -> returns line-0 data (wrap).
